// File: rtl/if_fetch_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_pkg
// Shared constants for the instruction-fetch stage: default bus widths,
// reset PC, fetch-queue depth and a counter-width helper.
// Optional feature macro used by if_fetch: IF_MISALIGN_CHECK_EN.
// ---------------------------------------------------------------------------
package if_fetch_pkg;

    localparam int INST_ADDR_BUS  = 32;  // PC / memory address width
    localparam int INST_BUS       = 32;  // instruction width
    localparam int DEF_RESET_PC   = 0;   // first fetch address after reset
    localparam int DEF_QDEPTH     = 2;   // queue entries == outstanding limit

    // Width needed to hold a count in the range 0..depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
// In-order synchronous FIFO of {pc, inst} pairs between instruction memory
// and the IF/ID register. Head is presented combinationally from registers.
// Ports:
//   clk, rst              clock, async active-low reset
//   push, push_pc/inst    write one entry at the tail
//   pop                   retire the head entry (ignored when empty)
//   flush                 empty the queue (wins over push/pop)
//   head_valid/pc/inst    head entry, pc/inst forced to 0 when empty
//   count                 current occupancy
// ---------------------------------------------------------------------------
module if_fetch_queue
    import if_fetch_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_BUS,
    parameter int INST_W = INST_BUS,
    parameter int QDEPTH = DEF_QDEPTH,
    parameter int CNT_W  = cnt_w(QDEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [INST_W-1:0] push_inst,
    input  logic              pop,
    input  logic              flush,
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_pc,
    output logic [INST_W-1:0] head_inst,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(QDEPTH);

    logic [ADDR_W-1:0] pc_q   [QDEPTH];
    logic [ADDR_W-1:0] pc_d   [QDEPTH];
    logic [INST_W-1:0] inst_q [QDEPTH];
    logic [INST_W-1:0] inst_d [QDEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_pop;

    always_comb begin
        pc_d     = pc_q;
        inst_d   = inst_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally since QDEPTH is a power of two.
            if (push) begin
                pc_d[wr_ptr_q]   = push_pc;
                inst_d[wr_ptr_q] = push_inst;
                wr_ptr_d         = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_valid = (count_q != '0);
    assign head_pc    = head_valid ? pc_q[rd_ptr_q]   : '0;
    assign head_inst  = head_valid ? inst_q[rd_ptr_q] : '0;
    assign count      = count_q;

endmodule

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
// Instruction-fetch stage: sequential PC generation, instruction-memory
// request/grant handshake, in-order response queue and EX redirect with
// discard of stale in-flight fetches.
// Ports:
//   clk, rst                       clock, async active-low reset
//   stall                          IF/ID not accepting this cycle
//   branch_en, branch_target       redirect from EX
//   mem_req/addr, mem_gnt          request handshake
//   mem_rvalid, mem_rdata          in-order read responses
//   if_valid, if_pc, if_inst       {pc, inst} presented to IF/ID
//   if_misalign                    sticky misaligned-target flag (only with
//                                  IF_MISALIGN_CHECK_EN defined)
// Optional feature macro: IF_MISALIGN_CHECK_EN.
// ---------------------------------------------------------------------------
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int                ADDR_W   = INST_ADDR_BUS,
    parameter int                INST_W   = INST_BUS,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter int                QDEPTH   = DEF_QDEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [INST_W-1:0] mem_rdata,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic              if_misalign
`endif
);

    localparam int CNT_W = cnt_w(QDEPTH);
    localparam int SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] LIMIT = SUM_W'(QDEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;  // next address to request
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;      // pc of next live response
    logic [CNT_W-1:0]  out_q, out_d;            // granted, not yet returned
    logic [CNT_W-1:0]  kill_q, kill_d;          // outstanding that are stale
    logic              started_q, started_d;    // holds off mem_req in cycle 0
    logic [CNT_W-1:0]  occ;
    logic [SUM_W-1:0]  credit;
    logic [ADDR_W-1:0] tgt;
    logic              pop, grant, push, req_ok;

`ifdef IF_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    assign tgt         = branch_target;
    assign misalign_d  = misalign_q | (branch_en && (branch_target[1:0] != 2'b00));
    assign req_ok      = !misalign_q;
    assign if_misalign = misalign_q;
`else
    logic unused_tgt_lsb;
    assign tgt            = {branch_target[ADDR_W-1:2], 2'b00};
    assign unused_tgt_lsb = ^branch_target[1:0];
    assign req_ok         = 1'b1;
`endif

    assign pop = if_valid && !stall;

    // A head retired this cycle frees its slot now, so a request may be
    // issued against it; this sustains one fetch per cycle with QDEPTH=2.
    assign credit  = {1'b0, occ} + {1'b0, out_q} - SUM_W'(pop);
    assign mem_req = started_q && req_ok && (credit < LIMIT);
    assign mem_addr = fetch_pc_q;
    assign grant    = mem_req && mem_gnt;

    // Responses are consumed while kill is non-zero; a response arriving in
    // the redirect cycle is dropped as well since the queue is flushed.
    assign push = mem_rvalid && (kill_q == '0) && !branch_en;

    always_comb begin
        started_d  = 1'b1;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        out_d      = out_q + CNT_W'(grant) - CNT_W'(mem_rvalid);
        kill_d     = kill_q;
        if (branch_en) begin
            fetch_pc_d = tgt;
            rsp_pc_d   = tgt;
            // Everything still in flight after this edge is stale, including
            // a grant for the old address taken in this very cycle.
            kill_d     = out_d;
        end else begin
            if (grant) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            if (push)  rsp_pc_d   = rsp_pc_q + ADDR_W'(4);
            if (mem_rvalid && (kill_q != '0)) kill_d = kill_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            started_q  <= 1'b0;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            out_q      <= '0;
            kill_q     <= '0;
`ifdef IF_MISALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            started_q  <= started_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            out_q      <= out_d;
            kill_q     <= kill_d;
`ifdef IF_MISALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    if_fetch_queue #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W),
        .QDEPTH (QDEPTH),
        .CNT_W  (CNT_W)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_pc    (rsp_pc_q),
        .push_inst  (mem_rdata),
        .pop        (pop),
        .flush      (branch_en),
        .head_valid (if_valid),
        .head_pc    (if_pc),
        .head_inst  (if_inst),
        .count      (occ)
    );

endmodule
